// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one byte-wide RAM/IO port between instruction fetch (IF) and load/store (LS).
//   Accepts 1/2/4-byte requests, issues them one byte per cycle on mem_a/mem_dout/mem_wr,
//   reassembles read bytes and pulses a done per transaction.
//   Ports: clk, rst (sync, active high), rdy (0 = freeze), flush (cancels IF and LS reads);
//          IF side  if_req/if_addr -> if_gnt/if_done/if_rdata (always a 4-byte read);
//          LS side  ls_req/ls_wr/ls_len/ls_addr/ls_wdata -> ls_gnt/ls_done/ls_rdata;
//          io_buffer_full throttles IO bytes; RAM side mem_din -> mem_dout/mem_a/mem_wr.
//   Build option: MEM_ARB_LS_PRIORITY_EN gives LS fixed priority on ties (default is round robin).
module mem_port_arbiter #(
  parameter logic [1:0]  IO_SEL = 2'b11,
  parameter int unsigned IO_GAP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_wr,
  input  logic [1:0]  ls_len,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  input  logic        io_buffer_full,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);
  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;
  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d, len_q, len_d, gap_q, gap_d, idx;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, acc_q, acc_d, cap_w, alast_q;
  logic [31:0] if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;
  logic        who_q, who_d, wr_q, wr_d, pend_q, pend_d;
  logic        if_gnt_q, if_gnt_d, ls_gnt_q, ls_gnt_d, if_done_q, if_done_d, ls_done_q, ls_done_d;
  logic        if_ok, ls_ok, pick_ls, pick_if, is_io, keep, issue, last;
`ifndef MEM_ARB_LS_PRIORITY_EN
  logic        last_q, last_d;
`endif
  // an accepted store (who=LS, wr=1) is never cancelled by flush
  assign keep    = who_q & wr_q;
  assign is_io   = addr_q[17:16] == IO_SEL;
  assign issue   = state_q == XFER && gap_q == 2'd0 && !(is_io && io_buffer_full) && !(flush && !keep);
  assign last    = cnt_q == len_q;
  assign idx     = cnt_q - 2'd1;
  assign if_ok   = if_req & ~flush;
  assign ls_ok   = ls_req & (~flush | ls_wr);
`ifdef MEM_ARB_LS_PRIORITY_EN
  assign pick_ls = ls_ok;
`else
  assign pick_ls = ls_ok & (~if_ok | ~last_q);
`endif
  assign pick_if = if_ok & ~pick_ls;
  // while frozen the last address is held so mem_din still returns the byte awaiting capture
  assign mem_a    = !rdy ? alast_q : issue ? addr_q + {30'd0, cnt_q} : 32'd0;
  assign mem_wr   = rdy & issue & wr_q;
  assign mem_dout = mem_wr ? wdata_q[{cnt_q, 3'b000} +: 8] : 8'd0;
  assign if_gnt   = if_gnt_q & rdy;
  assign ls_gnt   = ls_gnt_q & rdy;
  assign if_done  = if_done_q & rdy;
  assign ls_done  = ls_done_q & rdy;
  assign if_rdata = if_rdata_q;
  assign ls_rdata = ls_rdata_q;
  // read byte issued last cycle lands in mem_din now; cnt has already advanced past it
  always_comb begin
    cap_w = acc_q;
    if (pend_q) cap_w[{idx, 3'b000} +: 8] = mem_din;
  end
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    who_d      = who_q;
    acc_d      = cap_w;
    pend_d     = issue & ~wr_q;
    gap_d      = (issue && is_io) ? 2'(IO_GAP) : (gap_q != 2'd0 ? gap_q - 2'd1 : 2'd0);
    if_gnt_d   = 1'b0;
    ls_gnt_d   = 1'b0;
    if_done_d  = 1'b0;
    ls_done_d  = 1'b0;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
`ifndef MEM_ARB_LS_PRIORITY_EN
    last_d     = last_q;
`endif
    case (state_q)
      IDLE: if (pick_ls || pick_if) begin
        state_d  = XFER;
        cnt_d    = 2'd0;
        acc_d    = 32'd0;
        who_d    = pick_ls;
        wr_d     = pick_ls & ls_wr;
        addr_d   = pick_ls ? ls_addr : if_addr;
        len_d    = pick_ls ? (ls_len == 2'd2 ? 2'd3 : ls_len) : 2'd3;
        wdata_d  = ls_wdata;
        if_gnt_d = pick_if;
        ls_gnt_d = pick_ls;
`ifndef MEM_ARB_LS_PRIORITY_EN
        last_d   = pick_ls;
`endif
      end
      XFER: if (flush && !keep) state_d = IDLE;
        else if (issue) begin
          cnt_d = cnt_q + 2'd1;
          if (last) begin
            state_d   = wr_q ? IDLE : DRAIN;
            ls_done_d = wr_q;
          end
        end
      DRAIN: begin
        state_d = IDLE;
        if (!flush) begin
          if_done_d  = ~who_q;
          ls_done_d  = who_q;
          if_rdata_d = who_q ? if_rdata_q : cap_w;
          ls_rdata_d = who_q ? cap_w : ls_rdata_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      len_q      <= 2'd0;
      gap_q      <= 2'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      acc_q      <= 32'd0;
      alast_q    <= 32'd0;
      who_q      <= 1'b0;
      wr_q       <= 1'b0;
      pend_q     <= 1'b0;
      if_gnt_q   <= 1'b0;
      ls_gnt_q   <= 1'b0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      if_rdata_q <= 32'd0;
      ls_rdata_q <= 32'd0;
`ifndef MEM_ARB_LS_PRIORITY_EN
      last_q     <= 1'b0;
`endif
    end else if (rdy) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      gap_q      <= gap_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      acc_q      <= acc_d;
      alast_q    <= mem_a;
      who_q      <= who_d;
      wr_q       <= wr_d;
      pend_q     <= pend_d;
      if_gnt_q   <= if_gnt_d;
      ls_gnt_q   <= ls_gnt_d;
      if_done_q  <= if_done_d;
      ls_done_q  <= ls_done_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
`ifndef MEM_ARB_LS_PRIORITY_EN
      last_q     <= last_d;
`endif
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random transactions against a byte RAM and a reference model
module tb_mem_port_arbiter;
  localparam int IO_GAP = 1;
  logic        clk = 1'b0, rst = 1'b1, rdy = 1'b1, flush = 1'b0;
  logic        if_req = 1'b0, ls_req = 1'b0, ls_wr = 1'b0, io_buffer_full = 1'b0;
  logic [1:0]  ls_len = 2'd0;
  logic [31:0] if_addr = '0, ls_addr = '0, ls_wdata = '0;
  logic [7:0]  mem_din = '0;
  logic        if_gnt, if_done, ls_gnt, ls_done, mem_wr;
  logic [31:0] if_rdata, ls_rdata, mem_a;
  logic [7:0]  mem_dout;
  typedef struct {int c; logic [31:0] a; logic [7:0] d;} wr_t;
  wr_t         wq[$];
  logic [7:0]  ram [0:4095];
  logic [7:0]  ref_mem [0:4095];
  logic [31:0] tr [0:63];
  int          ei [0:3];
  int          cyc = 0, n_chk = 0, n_fail = 0;

  mem_port_arbiter #(.IO_SEL(2'b11), .IO_GAP(IO_GAP)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_len(ls_len), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (mem_wr) begin
      ram[mem_a[11:0]] <= mem_dout;
      wq.push_back('{cyc, mem_a, mem_dout});
    end
    mem_din <= ram[mem_a[11:0]];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic bit in_win(input int t, input int a, input int n);
    return t >= a && t < a + n;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
    logic [31:0] r = '0;
    for (int k = 0; k < n; k++) r[8*k +: 8] = ref_mem[12'(a + k)];
    return r;
  endfunction

  // issue cycles (offsets from request cycle) from the rules: one byte per free cycle,
  // no byte while frozen or while an IO sink is full, IO_GAP idle cycles after each IO byte
  task automatic model(input int n, input bit wr, input bit io, input int frz_at, input int frz_n,
                       input int full_n, output int d);
    int t = 1, nxt = 1;
    for (int k = 0; k < n; k++) begin
      while (in_win(t, frz_at, frz_n) || (io && in_win(t, 1, full_n)) || t < nxt) t++;
      ei[k] = t;
      nxt = t + 1 + (io ? IO_GAP : 0);
      t++;
    end
    d = ei[n-1] + 1;
    while (in_win(d, frz_at, frz_n)) d++;
    if (!wr) begin
      d++;
      while (in_win(d, frz_at, frz_n)) d++;
    end
  endtask

  task automatic ctl(input int off, input int fl_at, input int frz_at, input int frz_n, input int full_n);
    flush = off == fl_at;
    rdy = !in_win(off, frz_at, frz_n);
    io_buffer_full = in_win(off, 1, full_n);
  endtask

  task automatic op(input bit who, input bit wr, input logic [1:0] len, input logic [31:0] a, input logic [31:0] d,
                    input int fl_at, input int frz_at, input int frz_n, input int full_n,
                    output int gl, output int dl, output logic [31:0] rd);
    int c0, off;
    bit dn = 0;
    gl = -1; dl = -1; rd = '0;
    tick;
    c0 = cyc; off = 0;
    if (who) begin
      ls_req = 1; ls_wr = wr; ls_len = len; ls_addr = a; ls_wdata = d;
    end else begin
      if_req = 1; if_addr = a;
    end
    ctl(off, fl_at, frz_at, frz_n, full_n);
    while (!dn && off < 40) begin
      @(negedge clk);
      tr[off] = mem_a;
      if ((who ? ls_gnt : if_gnt) && gl < 0) gl = off;
      if (who ? ls_done : if_done) begin
        dn = 1; dl = off; rd = who ? ls_rdata : if_rdata;
      end
      tick;
      off = cyc - c0;
      if (gl >= 0) begin if_req = 0; ls_req = 0; end
      ctl(off, fl_at, frz_at, frz_n, full_n);
    end
    if_req = 0; ls_req = 0; flush = 0; rdy = 1; io_buffer_full = 0;
  endtask

  task automatic do_ls(input string tag, input bit wr, input logic [1:0] len, input logic [31:0] a,
                       input logic [31:0] d, input int fl_at, input int frz_at, input int frz_n, input int full_n);
    int gl, dl, ed, n, c0;
    logic [31:0] rd;
    n = len == 2'd2 ? 4 : int'(len) + 1;
    wq.delete();
    c0 = cyc + 1;
    op(1, wr, len, a, d, fl_at, frz_at, frz_n, full_n, gl, dl, rd);
    model(n, wr, a[17:16] == 2'b11, frz_at, frz_n, full_n, ed);
    chk({tag, "_gnt"}, gl, 1);
    chk({tag, "_done"}, dl, ed);
    if (wr) begin
      chk({tag, "_nwr"}, wq.size(), n);
      for (int k = 0; k < n && k < wq.size(); k++) begin
        chk({tag, "_wcyc"}, wq[k].c - c0, ei[k]);
        chk({tag, "_waddr"}, wq[k].a, a + k);
        chk({tag, "_wdata"}, {24'd0, wq[k].d}, {24'd0, d[8*k +: 8]});
      end
      for (int k = 0; k < n; k++) ref_mem[12'(a + k)] = d[8*k +: 8];
    end else begin
      chk({tag, "_rdata"}, rd, ref_read(a, n));
      chk({tag, "_nwr"}, wq.size(), 0);
    end
  endtask

  task automatic do_reset;
    tick; rst = 1;
    tick; tick; rst = 0;
  endtask

  initial begin
    int gl, dl, ng, nd, nw;
    logic [31:0] rd;
    bit win[$];
    for (int i = 0; i < 4096; i++) begin
      ram[i] = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;
    for (int i = 12'h100; i < 12'h104; i++) ref_mem[i] = ram[i];
    do_reset();
    @(negedge clk);
    chk("rst_if_gnt", {31'd0, if_gnt}, 0);
    chk("rst_ls_gnt", {31'd0, ls_gnt}, 0);
    chk("rst_if_done", {31'd0, if_done}, 0);
    chk("rst_ls_done", {31'd0, ls_done}, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_ls_rdata", ls_rdata, 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_dout", {24'd0, mem_dout}, 0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 0);

    op(0, 0, 2'd3, 32'h100, 0, -1, -1, 0, 0, gl, dl, rd);
    chk("if_gnt", gl, 1);
    chk("if_done", dl, 6);
    chk("if_rdata", rd, 32'h00000513);
    for (int k = 0; k < 4; k++) chk("if_addr", tr[k+1], 32'h100 + k);
    chk("if_drain_a", tr[5], 0);

    do_reset();
    tick;
    if_req = 1; if_addr = 32'h100; ls_req = 1; ls_wr = 0; ls_len = 2'd0; ls_addr = 32'h200;
    ng = 0; nd = 0;
    for (int i = 0; i < 100 && nd < 4; i++) begin
      @(negedge clk);
      if (if_gnt) begin win.push_back(0); ng++; end
      if (ls_gnt) begin win.push_back(1); ng++; end
      if (ls_done) chk("tie_ls_rdata", ls_rdata, ref_read(32'h200, 1));
      if (if_done) chk("tie_if_rdata", if_rdata, ref_read(32'h100, 4));
      if (if_done || ls_done) nd++;
      tick;
      if (ng >= 4) begin if_req = 0; ls_req = 0; end
    end
    if_req = 0; ls_req = 0;
    chk("tie_count", win.size(), 4);
    for (int k = 0; k < 4 && k < win.size(); k++)
`ifdef MEM_ARB_LS_PRIORITY_EN
      chk("tie_winner", {31'd0, win[k]}, 1);
`else
      chk("tie_winner", {31'd0, win[k]}, (k % 2 == 0) ? 1 : 0);
`endif

    do_ls("io_sw", 1, 2'd3, 32'h30000, 32'hDEADBEEF, -1, -1, 0, 3);
    do_ls("nio_sh", 1, 2'd1, 32'h700, $urandom, -1, -1, 0, 3);

    op(0, 0, 2'd3, 32'h100, 0, 3, -1, 0, 0, gl, dl, rd);
    chk("flush_if_gnt", gl, 1);
    chk("flush_if_nodone", dl, -1);
    chk("flush_if_a1", tr[1], 32'h100);
    chk("flush_if_a2", tr[2], 32'h101);
    chk("flush_if_a3", tr[3], 0);
    chk("flush_if_idle", tr[4], 0);
    do_ls("flush_sh", 1, 2'd1, 32'h80, $urandom, 2, -1, 0, 0);
    op(0, 0, 2'd3, 32'h100, 0, 0, -1, 0, 0, gl, dl, rd);
    chk("idleflush_if_gnt", gl, 2);
    chk("idleflush_if_done", dl, 7);
    do_ls("idleflush_sb", 1, 2'd0, 32'h90, $urandom, 0, -1, 0, 0);

    do_ls("frz_lw", 0, 2'd3, 32'h40, 0, -1, 2, 2, 0);
    do_ls("frz_sw", 1, 2'd3, 32'h50, $urandom, -1, 2, 2, 0);

    for (int i = 0; i < 16; i++)
      do_ls("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 32'h400 + $urandom_range(0, 2047),
            $urandom, -1, -1, 0, 0);
    for (int i = 0; i < 4; i++)
      do_ls("rnd_ld", 0, 2'($urandom_range(0, 3)), 32'h400 + $urandom_range(0, 2047), 0, -1, -1, 0, 0);

    tick;
    ls_req = 1; ls_wr = 1; ls_len = 2'd3; ls_addr = 32'hF00; ls_wdata = $urandom;
    tick; ls_req = 0;
    tick; rst = 1;
    tick; rst = 0;
    @(negedge clk);
    chk("midrst_mem_wr", {31'd0, mem_wr}, 0);
    chk("midrst_mem_a", mem_a, 0);
    nd = 0; nw = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ls_done) nd++;
      if (mem_wr) nw++;
    end
    chk("midrst_nodone", nd, 0);
    chk("midrst_nowr", nw, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
